// File: rtl/hs_peri_axi_regbank_if.sv
// AXI slave port bundle for the high-speed peripheral register bank.
// Channels grouped by handshake; clock and reset stay outside.
interface hs_peri_axi_regbank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
);
  localparam int BYTES = DATA_W / 8;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [BYTES-1:0]  wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/hs_peri_axi_regbank.sv
// Parametrised AXI slave register bank with independent read/write paths.
// Registers are exported flat on reg_q for peripheral control logic.
module hs_peri_axi_regbank #(
  parameter int                 DATA_W    = 64,
  parameter int                 ADDR_W    = 32,
  parameter int                 ID_W      = 8,
  parameter int                 NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                       acr_clk,
  input  logic                       acr_rst,
  hs_peri_axi_regbank_if.slave       axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * BYTES);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] B_INCR = 2'b01;

  function automatic logic hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[SZ +: IDX_W];
  endfunction

  function automatic logic legal(input logic [1:0] b, input logic [2:0] s);
    return (b[1] == 1'b0) && (s == 3'(SZ));
  endfunction

  // Error codes are ordered so the larger one wins: DECERR > SLVERR > OKAY.
  function automatic logic [1:0] emax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_next;

  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst, w_err, beat_err;
  logic              aw_hs, w_hs, w_end, w_ok, w_in, w_we;
  logic [IDX_W-1:0]  w_idx;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign w_end = w_hs && (w_cnt == w_len);
  assign w_ok  = legal(w_burst, w_size);
  assign w_in  = hit(w_addr);
  assign w_we  = w_hs && w_ok && w_in;
  assign w_idx = idx(w_addr);

  always_comb begin
    beat_err = OKAY;
    if (!w_ok) beat_err = SLVERR;
    if (axi.wlast != (w_cnt == w_len)) beat_err = SLVERR;
    if (!w_in) beat_err = DECERR;
  end

  always_ff @(posedge acr_clk or posedge acr_rst)
    if (acr_rst) w_state <= W_IDLE;
    else         w_state <= w_next;

  always_comb begin
    w_next      = w_state;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        axi.awready = !acr_rst;
        if (aw_hs) w_next = W_DATA;
      end
      W_DATA: begin
        axi.wready = 1'b1;
        if (w_end) w_next = W_RESP;
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge acr_clk or posedge acr_rst)
    if (acr_rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= OKAY;
    end else if (aw_hs) begin
      w_id    <= axi.awid;
      w_addr  <= axi.awaddr;
      w_len   <= axi.awlen;
      w_size  <= axi.awsize;
      w_burst <= axi.awburst;
      w_cnt   <= '0;
      w_err   <= OKAY;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 4'd1;
      w_err <= emax(w_err, beat_err);
      if (w_burst == B_INCR) w_addr <= w_addr + STEP;
    end

  assign axi.bid   = w_id;
  assign axi.bresp = w_err;

  always_ff @(posedge acr_clk or posedge acr_rst)
    if (acr_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (w_we) begin
      for (int b = 0; b < BYTES; b++)
        if (axi.wstrb[b]) regs[w_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
    end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t r_state, r_next;

  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, ld_addr;
  logic [3:0]        r_len, r_cnt;
  logic [1:0]        r_burst, ld_resp, rresp_q;
  logic              r_ok, ld_ok, ld_last, ld_hit;
  logic              ar_hs, r_hs, r_step, r_done;
  logic              rvalid_q, rlast_q;
  logic [DATA_W-1:0] ld_data, rdata_q;
  logic [IDX_W-1:0]  ld_idx;

  assign ar_hs  = axi.arvalid && axi.arready;
  assign r_hs   = rvalid_q && axi.rready;
  assign r_step = r_hs && !rlast_q;
  assign r_done = r_hs && rlast_q;

  // Beat loader: beat 0 from the AR channel, later beats from the latched burst.
  always_comb begin
    if (r_state == R_IDLE) begin
      ld_addr = axi.araddr;
      ld_ok   = legal(axi.arburst, axi.arsize);
      ld_last = (axi.arlen == 4'd0);
    end else begin
      ld_addr = (r_burst == B_INCR) ? r_addr + STEP : r_addr;
      ld_ok   = r_ok;
      ld_last = ((r_cnt + 4'd1) == r_len);
    end
    ld_hit  = hit(ld_addr);
    ld_idx  = ld_hit ? idx(ld_addr) : '0;
    ld_data = '0;
    ld_resp = OKAY;
    if (!ld_ok) ld_resp = SLVERR;
    else if (!ld_hit) ld_resp = DECERR;
    else ld_data = regs[ld_idx];
  end

  always_ff @(posedge acr_clk or posedge acr_rst)
    if (acr_rst) r_state <= R_IDLE;
    else         r_state <= r_next;

  always_comb begin
    r_next      = r_state;
    axi.arready = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        axi.arready = !acr_rst;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: if (r_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge acr_clk or posedge acr_rst)
    if (acr_rst) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_burst  <= '0;
      r_ok     <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      rlast_q  <= 1'b0;
    end else if (ar_hs) begin
      r_id     <= axi.arid;
      r_addr   <= axi.araddr;
      r_len    <= axi.arlen;
      r_cnt    <= '0;
      r_burst  <= axi.arburst;
      r_ok     <= ld_ok;
      rvalid_q <= 1'b1;
      rdata_q  <= ld_data;
      rresp_q  <= ld_resp;
      rlast_q  <= ld_last;
    end else if (r_step) begin
      r_addr  <= ld_addr;
      r_cnt   <= r_cnt + 4'd1;
      rdata_q <= ld_data;
      rresp_q <= ld_resp;
      rlast_q <= ld_last;
    end else if (r_done) begin
      rvalid_q <= 1'b0;
    end

  assign axi.rid    = r_id;
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = rresp_q;
  assign axi.rlast  = rlast_q;
  assign axi.rvalid = rvalid_q;

endmodule

// File: tb/tb_hs_peri_axi_regbank.sv
// Self-checking bench for hs_peri_axi_regbank (64-bit, 16 registers).
// Read beats are scoreboarded against a reference register model.
module tb_hs_peri_axi_regbank;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int NR = 16;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [63:0] RV   = 64'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*DW-1:0] reg_q;

  hs_peri_axi_regbank_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) axi ();

  hs_peri_axi_regbank #(
    .DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .NUM_REGS(NR),
    .BASE_ADDR(BASE), .RESET_VAL(RV)
  ) dut (
    .acr_clk(clk),
    .acr_rst(rst),
    .axi(axi.slave),
    .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [63:0] model [NR];
  int checks = 0;
  int errors = 0;

  // ---------- reference model ----------
  function automatic bit m_legal(input logic [1:0] b, input logic [2:0] s);
    return (b == 2'b00 || b == 2'b01) && s == 3'd3;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(NR * 8));
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [63:0] d,
                         input logic [7:0] s, input bit ok);
    int k;
    if (ok && m_hit(a)) begin
      k = int'((a - BASE) >> 3);
      for (int b = 0; b < 8; b++)
        if (s[b]) model[k][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic push_rd(input logic [7:0] id, input logic [31:0] a,
                         input logic [3:0] len, input logic [1:0] bu,
                         input logic [2:0] sz);
    rbeat_t e;
    logic [31:0] x;
    for (int i = 0; i <= int'(len); i++) begin
      x = (bu == 2'b01) ? a + 32'(8 * i) : a;
      e.id = id;
      e.last = (i == int'(len));
      e.data = '0;
      if (!m_legal(bu, sz)) e.resp = 2'b10;
      else if (!m_hit(x)) e.resp = 2'b11;
      else begin
        e.resp = 2'b00;
        e.data = model[int'((x - BASE) >> 3)];
      end
      rq.push_back(e);
    end
  endtask

  // ---------- bus drivers ----------
  task automatic aw_send(input logic [7:0] id, input logic [31:0] a,
                         input logic [3:0] len, input logic [1:0] bu,
                         input logic [2:0] sz);
    bit ok = 0;
    axi.awid = id; axi.awaddr = a; axi.awlen = len;
    axi.awburst = bu; axi.awsize = sz; axi.awvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = axi.awready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready never seen, required 1");
    end
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    bit ok = 0;
    axi.wdata = d; axi.wstrb = s; axi.wlast = l; axi.wvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = axi.wready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL w_timeout: wready never seen, required 1");
    end
    @(posedge clk); #1;
    axi.wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] a,
                         input logic [3:0] len, input logic [1:0] bu,
                         input logic [2:0] sz);
    bit ok = 0;
    axi.arid = id; axi.araddr = a; axi.arlen = len;
    axi.arburst = bu; axi.arsize = sz; axi.arvalid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = axi.arready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready never seen, required 1");
    end
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic get_b(output logic [7:0] id, output logic [1:0] resp);
    bit ok = 0;
    id = '0; resp = '0;
    axi.bready = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = axi.bvalid;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid never seen, required 1");
      resp = 2'bxx;
    end else begin
      id = axi.bid; resp = axi.bresp;
    end
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask

  // Pops the scoreboard on every R handshake; checks hold-stability under stall.
  task automatic r_drain(input int n, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    rbeat_t held, e;
    while (got < n && cyc < 400) begin
      axi.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (axi.rvalid) begin
        if (stalled) begin
          checks++;
          if ({axi.rid, axi.rdata, axi.rresp, axi.rlast} !==
              {held.id, held.data, held.resp, held.last}) begin
            errors++;
            $display("FAIL r_stable: got %h/%h/%0d/%b required %h/%h/%0d/%b",
                     axi.rid, axi.rdata, axi.rresp, axi.rlast,
                     held.id, held.data, held.resp, held.last);
          end
        end
        if (axi.rready) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL r_extra: unexpected beat %h, required none", axi.rdata);
          end else begin
            e = rq.pop_front();
            if ({axi.rid, axi.rdata, axi.rresp, axi.rlast} !==
                {e.id, e.data, e.resp, e.last}) begin
              errors++;
              $display("FAIL r_beat%0d: got id=%h data=%h resp=%0d last=%b required id=%h data=%h resp=%0d last=%b",
                       got, axi.rid, axi.rdata, axi.rresp, axi.rlast,
                       e.id, e.data, e.resp, e.last);
            end
          end
          got++;
          stalled = 0;
        end else begin
          held = '{axi.rid, axi.rdata, axi.rresp, axi.rlast};
          stalled = 1;
        end
      end else if (!rnd && got > 0) begin
        checks++; errors++;
        $display("FAIL r_gap: rvalid=0 after beat %0d, required 1", got);
      end
      @(posedge clk); #1;
      cyc++;
    end
    axi.rready = 1'b0;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL r_timeout: got %0d beats, required %0d", got, n);
    end
    @(negedge clk);
    checks++;
    if (axi.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_drop: rvalid=%b after last beat, required 0", axi.rvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_regs(input string nm);
    int bad = -1;
    for (int i = NR - 1; i >= 0; i--)
      if (reg_q[i*DW +: DW] !== model[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: reg%0d got %h required %h",
               nm, bad, reg_q[bad*DW +: DW], model[bad]);
    end
  endtask

  task automatic chk_b(input string nm, input logic [7:0] eid,
                       input logic [1:0] er);
    logic [7:0] id;
    logic [1:0] r;
    get_b(id, r);
    checks++;
    if (id !== eid || r !== er) begin
      errors++;
      $display("FAIL %s: bid=%h bresp=%0d required bid=%h bresp=%0d",
               nm, id, r, eid, er);
    end
  endtask

  // ---------- scenarios ----------
  task automatic test_reset();
    for (int i = 0; i < NR; i++) model[i] = RV;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_regs("reset_regs");
    checks++;
    if ({axi.awready, axi.wready, axi.bvalid, axi.arready,
         axi.rvalid, axi.rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: aw/w/b/ar/rv/rl=%b required 000000",
               {axi.awready, axi.wready, axi.bvalid, axi.arready,
                axi.rvalid, axi.rlast});
    end
    checks++;
    if ({axi.bid, axi.bresp, axi.rid, axi.rdata, axi.rresp} !== '0) begin
      errors++;
      $display("FAIL reset_payload: bid=%h bresp=%0d rid=%h rdata=%h rresp=%0d required 0",
               axi.bid, axi.bresp, axi.rid, axi.rdata, axi.rresp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi.awready, axi.arready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: awready/arready=%b required 11",
               {axi.awready, axi.arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_strobe();
    aw_send(8'h3C, 32'h10, 4'd0, 2'b01, 3'd3);
    #2;
    checks++;
    if (axi.wready !== 1'b1) begin
      errors++;
      $display("FAIL aw_to_w: wready=%b one cycle after AW, required 1", axi.wready);
    end
    w_send(64'h1122334455667788, 8'h0F, 1'b1);
    m_write(32'h10, 64'h1122334455667788, 8'h0F, 1);
    #2;
    checks++;
    if (axi.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL w_to_b: bvalid=%b one cycle after W, required 1", axi.bvalid);
    end
    chk_b("strobe_b", 8'h3C, 2'b00);
    chk_regs("strobe_regs");
  endtask

  task automatic test_incr_burst();
    logic [63:0] d;
    logic [7:0]  s;
    aw_send(8'h11, 32'h0, 4'd15, 2'b01, 3'd3);
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      s = (i == 9) ? 8'hF0 : 8'hFF;
      w_send(d, s, i == 15);
      m_write(32'(8 * i), d, s, 1);
    end
    chk_b("incr_b", 8'h11, 2'b00);
    chk_regs("incr_regs");
  endtask

  task automatic test_read_burst();
    push_rd(8'h07, 32'h0, 4'd3, 2'b01, 3'd3);
    ar_send(8'h07, 32'h0, 4'd3, 2'b01, 3'd3);
    r_drain(4, 0);
    push_rd(8'h08, 32'h18, 4'd2, 2'b00, 3'd3);
    ar_send(8'h08, 32'h18, 4'd2, 2'b00, 3'd3);
    r_drain(3, 0);
  endtask

  task automatic test_read_boundary();
    push_rd(8'h09, BASE + 32'(NR * 8) - 32'd8, 4'd1, 2'b01, 3'd3);
    ar_send(8'h09, BASE + 32'(NR * 8) - 32'd8, 4'd1, 2'b01, 3'd3);
    r_drain(2, 0);
    push_rd(8'h0A, 32'h8, 4'd1, 2'b01, 3'd2);
    ar_send(8'h0A, 32'h8, 4'd1, 2'b01, 3'd2);
    r_drain(2, 0);
  endtask

  task automatic test_illegal_write();
    aw_send(8'h44, 32'h20, 4'd1, 2'b10, 3'd3);
    w_send(64'hDEADBEEF_00000001, 8'hFF, 1'b0);
    w_send(64'hDEADBEEF_00000002, 8'hFF, 1'b1);
    chk_b("wrap_b", 8'h44, 2'b10);
    chk_regs("wrap_regs");
    aw_send(8'h45, BASE + 32'(NR * 8), 4'd0, 2'b01, 3'd3);
    w_send(64'hCAFE, 8'hFF, 1'b1);
    chk_b("decerr_b", 8'h45, 2'b11);
    chk_regs("decerr_regs");
  endtask

  task automatic test_wlast_err();
    aw_send(8'h55, 32'h30, 4'd1, 2'b01, 3'd3);
    w_send(64'hAAAA_0000_0000_0006, 8'hFF, 1'b1);
    m_write(32'h30, 64'hAAAA_0000_0000_0006, 8'hFF, 1);
    w_send(64'hBBBB_0000_0000_0007, 8'hFF, 1'b1);
    m_write(32'h38, 64'hBBBB_0000_0000_0007, 8'hFF, 1);
    chk_b("wlast_b", 8'h55, 2'b10);
    chk_regs("wlast_regs");
  endtask

  task automatic test_concurrent();
    logic [63:0] nv = 64'h0123_4567_89AB_CDEF;
    aw_send(8'h21, 32'h28, 4'd0, 2'b01, 3'd3);
    push_rd(8'h22, 32'h28, 4'd0, 2'b01, 3'd3);
    axi.wdata = nv; axi.wstrb = 8'hFF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
    axi.arid = 8'h22; axi.araddr = 32'h28; axi.arlen = 4'd0;
    axi.arburst = 2'b01; axi.arsize = 3'd3; axi.arvalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({axi.wready, axi.arready} !== 2'b11) begin
      errors++;
      $display("FAIL conc_ready: wready/arready=%b required 11",
               {axi.wready, axi.arready});
    end
    @(posedge clk); #1;
    axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    m_write(32'h28, nv, 8'hFF, 1);
    r_drain(1, 0);
    chk_b("conc_b", 8'h21, 2'b00);
    push_rd(8'h23, 32'h28, 4'd0, 2'b01, 3'd3);
    ar_send(8'h23, 32'h28, 4'd0, 2'b01, 3'd3);
    r_drain(1, 0);
  endtask

  task automatic test_rready_random();
    push_rd(8'h5A, 32'h0, 4'd15, 2'b01, 3'd3);
    ar_send(8'h5A, 32'h0, 4'd15, 2'b01, 3'd3);
    r_drain(16, 1);
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d beats left, required 0", rq.size());
    end
  endtask

  initial begin
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0;
    axi.awsize = 0; axi.awburst = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
    axi.bready = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0;
    axi.arsize = 0; axi.arburst = 0;
    axi.rready = 0;
    test_reset();
    test_write_strobe();
    test_incr_burst();
    test_read_burst();
    test_read_boundary();
    test_illegal_write();
    test_wlast_err();
    test_concurrent();
    test_rready_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hs_peri_axi_regbank.md
Name: hs_peri_axi_regbank

Overview:
Parametrised AXI slave register bank for the high-speed peripheral subsystem. It generalises the subsystem's fixed 64-bit AXI slave port in data width, ID width and register count. It adds write IDs, INCR/FIXED burst handling, byte strobes, error responses, and independent concurrent read and write paths. Register contents are exported as a flat vector to drive peripheral control logic.

Parameters:
DATA_W, 64, AXI data width; legal values are 32 and 64; BYTES = DATA_W/8
ADDR_W, 32, AXI address width
ID_W, 8, AXI ID width for AW, B, AR and R
NUM_REGS, 16, number of DATA_W-bit registers (1..256)
BASE_ADDR, 0, byte base address of register 0; BYTES-aligned
RESET_VAL, 0, DATA_W reset value loaded into every register

Ports:
acr_clk  in  1  clock
acr_rst  in  1  asynchronous active-high reset
axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/4/3/2/1  write address channel
axi_awready  out  1  write address ready
axi_wdata/wstrb/wlast/wvalid  in  DATA_W/BYTES/1/1  write data channel
axi_wready  out  1  write data ready
axi_bid/bresp/bvalid  out  ID_W/2/1  write response
axi_bready  in  1  response ready
axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/4/3/2/1  read address channel
axi_arready  out  1  read address ready
axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data channel
axi_rready  in  1  read data ready
reg_q  out  NUM_REGS*DATA_W  register contents; reg i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async assert, sync deassert handled upstream): all registers = RESET_VAL. awready, wready, bvalid, arready, rvalid and rlast = 0. bid, bresp, rid, rdata and rresp = 0. Both FSMs go to IDLE. A reset mid-burst aborts the burst with no response.
- Decode: off = addr - BASE_ADDR.
  - Beat is in range iff addr >= BASE_ADDR and off < NUM_REGS*BYTES.
  - idx = off / BYTES; the low address bits are ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready = 1. An AW handshake latches id, addr, len, size and burst, clears the beat count and err, then enters W_DATA.
  - W_DATA: wready = 1. On each W handshake:
    - If in range and the burst is legal, write the bytes where wstrb[b] = 1.
    - Out of range sets err to DECERR; it is not written.
    - Illegal burst means awburst = WRAP or reserved, or awsize != log2(BYTES). It sets err to SLVERR; no bytes are written for the whole burst.
    - INCR advances addr by BYTES per beat; FIXED holds addr.
    - wlast asserted on a beat other than beat awlen, or deasserted on beat awlen, sets SLVERR. The data is still written.
    - The burst ends on handshake beat awlen; wready drops the next cycle.
  - W_RESP: bvalid = 1, bid = latched id, bresp = accumulated error (precedence DECERR > SLVERR > OKAY). Holds until bready, then W_IDLE.
  - Timing: AW accept at cycle N gives wready at N+1. The last W at cycle M gives bvalid at M+1.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready = 1. An AR handshake latches the fields and registers beat 0 (rdata, rresp, rlast = (arlen == 0)). rvalid is set in the next cycle.
  - R_DATA: when rvalid && rready and this is not the last beat, the next beat's rdata, rresp and rlast load in the same cycle. Result: 1 beat/cycle under continuous rready.
  - When the last beat handshakes, the FSM returns to R_IDLE; rvalid = 0 the next cycle.
  - Per-beat rresp: out of range gives DECERR with rdata = 0. An illegal burst gives SLVERR on every beat with rdata = 0. Otherwise OKAY.
  - rdata, rid, rresp and rlast are stable while rvalid && !rready.
- Read and write paths run concurrently. If a write and a read beat load hit the same register in one cycle, the read returns the pre-write value.
- reg_q is driven directly from the registers; an update is visible in the cycle after the write beat.
- One outstanding transaction per direction. AW and AR are not accepted outside IDLE.

Test Plan:
- Reset with DATA_W=64, RESET_VAL=0xA5 -> reg_q all 0xA5. All valids and readies are 0 during reset; awready = arready = 1 after release.
- AW id=0x3C, addr=0x10, len=0, INCR; W data=0x1122334455667788, strb=0x0F -> reg 2 low 32 bits = 0x55667788, high bits unchanged. bid=0x3C, bresp=OKAY, bvalid at the cycle after W.
- AR id=0x7, addr=0x0, len=3, INCR, rready held 1 -> 4 consecutive beats from regs 0..3, rlast on beat 3 only, rid=0x7, rresp=OKAY.
- AR addr = BASE+NUM_REGS*BYTES-8, len=1, INCR -> beat0 OKAY with valid data; beat1 DECERR with rdata=0 and rlast=1.
- AW burst=WRAP, len=1, followed by 2 W beats -> no register changes, bresp=SLVERR. Separately, wlast asserted on beat 0 of a len=1 burst -> both beats are written and bresp=SLVERR.
- Concurrent write to reg 5 and read of reg 5 in the same cycle -> rdata = old value; a follow-up read returns the new value. Also toggle rready randomly on a len=15 read -> all 16 beats are delivered in order with stable payload while stalled.
